branch_target_buffer: RTL

Parametrised fetch-stage branch predictor. It replaces the purely combinational decode-time target computation with a tagged, direct-mapped target buffer, per-entry saturating direction counters and a return-address stack. The fetch stage presents the PC and gets hit, taken and target in the same cycle. The execute stage writes resolved control-flow outcomes back through the update port.

---
 rtl/bpb_pkg.sv | 39 +++
 rtl/return_address_stack.sv | 42 ++++
 rtl/branch_target_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/bpb_pkg.sv
// Shared types and counter helpers for the fetch-stage branch predictor.
package bpb_pkg;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JUMP   = 2'd1,
    CALL   = 2'd2,
    RET    = 2'd3
  } kind_t;

  // Entry fields are sized for the widest supported configuration; unused high bits stay zero.
  localparam int TAG_MAX = 30;
  localparam int CTR_MAX = 8;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    kind_t              kind;
    logic [CTR_MAX-1:0] ctr;
    logic [31:0]        target;
  } btb_entry_t;

  function automatic logic [CTR_MAX-1:0] ctr_max(input int bits);
    return CTR_MAX'((1 << bits) - 1);
  endfunction

  function automatic logic [CTR_MAX-1:0] ctr_weak_taken(input int bits);
    return CTR_MAX'(1 << (bits - 1));
  endfunction

  function automatic logic [CTR_MAX-1:0] ctr_sat_inc(input logic [CTR_MAX-1:0] c, input int bits);
    return (c >= ctr_max(bits)) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_MAX-1:0] ctr_sat_dec(input logic [CTR_MAX-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack; top is combinational, push/pop visible next cycle.
// Overflow overwrites the oldest entry; pop on empty does nothing.
module return_address_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_ptr;
  logic [PW:0]   count;

  assign top_ptr = ptr - 1'b1;
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop && !empty) begin
      mem[top_ptr] <= push_data;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + 1'b1;
      if (count != (PW+1)'(DEPTH)) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= top_ptr;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped tagged BTB with saturating direction counters and a return stack.
// Lookup is combinational; updates and stack changes are seen the next cycle.
module branch_target_buffer
  import bpb_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f_pc,
  input  logic        f_fire,
  output logic        f_hit,
  output logic        f_taken,
  output logic [31:0] f_target,
  input  logic        u_valid,
  input  logic [31:0] u_pc,
  input  logic [1:0]  u_kind,
  input  logic        u_taken,
  input  logic [31:0] u_target
);

  localparam int IDX = $clog2(ENTRIES);

  btb_entry_t         mem [ENTRIES];
  logic [IDX-1:0]     f_idx, u_idx;
  logic [TAG_MAX-1:0] f_tag, u_tag;
  logic [31:0]        f_seq;
  kind_t              f_kind, u_kind_e;
  logic               u_hit;
  logic               ras_push, ras_pop, ras_empty;
  logic [31:0]        ras_top;
  logic               unused_bits;

  assign f_idx    = f_pc[IDX+1:2];
  assign f_tag    = TAG_MAX'(f_pc[IDX+TAG_BITS+1:IDX+2]);
  assign u_idx    = u_pc[IDX+1:2];
  assign u_tag    = TAG_MAX'(u_pc[IDX+TAG_BITS+1:IDX+2]);
  assign u_kind_e = kind_t'(u_kind);
  assign f_seq    = f_pc + 32'd4;
  assign f_kind   = mem[f_idx].kind;

  assign f_hit = mem[f_idx].valid && (mem[f_idx].tag == f_tag);
  assign u_hit = mem[u_idx].valid && (mem[u_idx].tag == u_tag);

  assign unused_bits = ^{u_pc[1:0], u_pc[31:IDX+TAG_BITS+2]};

  always_comb begin
    f_taken  = 1'b0;
    f_target = f_seq;
    if (f_hit) begin
      case (f_kind)
        BRANCH: begin
          f_taken  = mem[f_idx].ctr[CTR_BITS-1];
          f_target = f_taken ? mem[f_idx].target : f_seq;
        end
        RET: begin
          f_taken  = 1'b1;
          f_target = ras_empty ? mem[f_idx].target : ras_top;
        end
        default: begin
          f_taken  = 1'b1;
          f_target = mem[f_idx].target;
        end
      endcase
    end
  end

  assign ras_push = f_fire && f_hit && (f_kind == CALL);
  assign ras_pop  = f_fire && f_hit && (f_kind == RET);

  return_address_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (f_seq),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  // No write-to-read bypass: lookups in the update cycle see the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) mem[i].valid <= 1'b0;
    end else if (u_valid) begin
      if (u_hit) begin
        mem[u_idx].kind <= u_kind_e;
        if (u_kind_e == BRANCH)
          mem[u_idx].ctr <= u_taken ? ctr_sat_inc(mem[u_idx].ctr, CTR_BITS)
                                    : ctr_sat_dec(mem[u_idx].ctr);
        if (u_taken) mem[u_idx].target <= u_target;
      end else if (u_taken) begin
        mem[u_idx] <= '{valid: 1'b1, tag: u_tag, kind: u_kind_e,
                        ctr: ctr_weak_taken(CTR_BITS), target: u_target};
      end
    end
  end

endmodule
